// File: rtl/dataflow_deadlock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : dataflow_deadlock_monitor
// Description : N-process deadlock monitor for HLS dataflow regions. It
//               declares deadlock when the same set of blocked processes
//               stays stable for STALL_CYCLES consecutive cycles. It then
//               latches that set and streams the blocked process IDs out
//               over a valid/ready report port.
//               Optional feature macro: DL_STALL_HIST_EN adds per-process
//               stall-cycle histogram counters, reported on rpt_stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module dataflow_deadlock_monitor #(
    parameter int N_PROC       = 2,
    parameter int STALL_CYCLES = 16,
    parameter int CNT_W        = 16,
    localparam int IDW         = (N_PROC > 1) ? $clog2(N_PROC) : 1
) (
    input  logic              dl_clock,
    input  logic              dl_reset,
    input  logic              all_finish,
    input  logic [N_PROC-1:0] proc_blk,
    input  logic [N_PROC-1:0] proc_done,
    input  logic              dl_clear,
    output logic              dl_detect_out,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [IDW-1:0]    rpt_proc_id,
    output logic              rpt_last,
    output logic [CNT_W-1:0]  rpt_stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_REPORT = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  c_WD_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_WD_TARGET = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_WD_MAX    = '1;
    localparam logic [N_PROC-1:0] c_BIT0      = N_PROC'(1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_wd;
    logic [N_PROC-1:0] r_prev_blk;
    logic [N_PROC-1:0] r_snap_rem;
    logic              r_detect;
    logic              r_rpt_valid;
    logic [IDW-1:0]    r_rpt_id;
    logic              r_rpt_last;

    logic              w_cand;
    logic              w_blk_changed;
    logic              w_handshake;
    logic [IDW-1:0]    w_pop_id;
    logic [N_PROC-1:0] w_pop_rem;
    logic              w_pop_last;

    // Every process is blocked or done-held, at least one is truly blocked,
    // and the design as a whole has not finished.
    assign w_cand        = (&(proc_blk | proc_done)) & (|proc_blk) & ~all_finish;
    assign w_blk_changed = (proc_blk != r_prev_blk);
    assign w_handshake   = r_rpt_valid & rpt_ready;

    // Lowest still-unreported process in the snapshot; it is the next entry.
    always_comb begin
        w_pop_id = '0;
        for (int i = N_PROC - 1; i >= 0; i--) begin
            if (r_snap_rem[i]) begin
                w_pop_id = IDW'(i);
            end
        end
    end

    assign w_pop_rem  = r_snap_rem & ~(c_BIT0 << w_pop_id);
    assign w_pop_last = (w_pop_rem == '0);

    // Watchdog FSM: stability counting, snapshot capture and report walk.
    always_ff @(posedge dl_clock or posedge dl_reset) begin
        if (dl_reset) begin
            r_state     <= S_IDLE;
            r_wd        <= '0;
            r_prev_blk  <= '0;
            r_snap_rem  <= '0;
            r_detect    <= 1'b0;
            r_rpt_valid <= 1'b0;
            r_rpt_id    <= '0;
            r_rpt_last  <= 1'b0;
        end else begin
            r_prev_blk <= proc_blk;
            if (dl_clear) begin
                r_state     <= S_IDLE;
                r_wd        <= '0;
                r_snap_rem  <= '0;
                r_detect    <= 1'b0;
                r_rpt_valid <= 1'b0;
                r_rpt_id    <= '0;
                r_rpt_last  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cand) begin
                            r_wd <= c_WD_ONE;
                            if (STALL_CYCLES == 1) begin
                                r_state    <= S_REPORT;
                                r_snap_rem <= proc_blk;
                                r_detect   <= 1'b1;
                            end else begin
                                r_state <= S_COUNT;
                            end
                        end
                    end
                    S_COUNT: begin
                        if (!w_cand) begin
                            r_state <= S_IDLE;
                            r_wd    <= '0;
                        end else if (w_blk_changed) begin
                            // A different blocked set restarts the stability window.
                            r_wd <= c_WD_ONE;
                        end else if (r_wd == c_WD_TARGET) begin
                            r_state    <= S_REPORT;
                            r_snap_rem <= proc_blk;
                            r_detect   <= 1'b1;
                        end else if (r_wd != c_WD_MAX) begin
                            r_wd <= r_wd + c_WD_ONE;
                        end
                    end
                    S_REPORT: begin
                        // The first entry loads one cycle after detection; later
                        // entries load on each handshake so a held-high ready
                        // drains one entry per cycle.
                        if (!r_rpt_valid || (w_handshake && !r_rpt_last)) begin
                            r_rpt_valid <= 1'b1;
                            r_rpt_id    <= w_pop_id;
                            r_rpt_last  <= w_pop_last;
                            r_snap_rem  <= w_pop_rem;
                        end else if (w_handshake) begin
                            r_state     <= S_HALT;
                            r_rpt_valid <= 1'b0;
                            r_rpt_id    <= '0;
                            r_rpt_last  <= 1'b0;
                        end
                    end
                    S_HALT: begin
                        r_state <= S_HALT;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign dl_detect_out = r_detect;
    assign rpt_valid     = r_rpt_valid;
    assign rpt_proc_id   = r_rpt_id;
    assign rpt_last      = r_rpt_last;

`ifdef DL_STALL_HIST_EN
    logic [CNT_W-1:0] r_hist [N_PROC];
    logic [CNT_W-1:0] w_stall_cnt;

    for (genvar g = 0; g < N_PROC; g++) begin : g_hist
        // Count blocked cycles while monitoring; frozen once a report is pending.
        always_ff @(posedge dl_clock or posedge dl_reset) begin
            if (dl_reset) begin
                r_hist[g] <= '0;
            end else if (dl_clear) begin
                r_hist[g] <= '0;
            end else if (((r_state == S_IDLE) || (r_state == S_COUNT)) &&
                         proc_blk[g] && (r_hist[g] != c_WD_MAX)) begin
                r_hist[g] <= r_hist[g] + c_WD_ONE;
            end
        end
    end

    // Select the histogram entry of the process currently being reported.
    always_comb begin
        w_stall_cnt = '0;
        for (int i = 0; i < N_PROC; i++) begin
            if (r_rpt_id == IDW'(i)) begin
                w_stall_cnt = r_hist[i];
            end
        end
    end

    assign rpt_stall_cnt = w_stall_cnt;
`else
    assign rpt_stall_cnt = '0;
`endif

endmodule
`default_nettype wire
